// File: rtl/hex_scan_driver_if.sv
// Display-side bundle for hex_scan_driver: capture handshake, data word,
// blanking control and the multiplexed segment/digit outputs.
interface hex_scan_driver_if;
  logic [31:0] hexDisplay;
  logic        update_req;
  logic        update_ack;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [7:0]  an;

  modport master (
    output hexDisplay, update_req, blank_lz,
    input  update_ack, seg, an
  );

  modport slave (
    input  hexDisplay, update_req, blank_lz,
    output update_ack, seg, an
  );
endinterface

// File: rtl/hex_scan_driver.sv
// Captures a 32-bit word over a 4-phase handshake and scans its eight nibbles
// onto an active-low seven-segment display with optional leading-zero blanking.
module hex_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic              clock,
  input logic              reset,
  hex_scan_driver_if.slave bus
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  logic [31:0]   r_data;
  logic          r_ack;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;

  logic [2:0]    w_msd;
  logic [3:0]    w_nib;
  logic          w_blank;
  logic          w_wrap;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Index of the most significant non-zero nibble; 0 when the word is zero.
  always_comb begin
    w_msd = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (r_data[4*k +: 4] != 4'h0) w_msd = 3'(k);
    end
  end

  assign w_nib   = r_data[{r_idx, 2'b00} +: 4];
  assign w_blank = bus.blank_lz && (r_idx > w_msd);
  assign w_wrap  = (r_cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data <= '0;
      r_ack  <= 1'b0;
    end else if (bus.update_req && !r_ack) begin
      r_data <= bus.hexDisplay;
      r_ack  <= 1'b1;
    end else if (!bus.update_req && r_ack) begin
      r_ack  <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Output register lags the digit index by one edge; dwell per digit is unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_an  <= '1;
      r_seg <= '1;
    end else begin
      r_an  <= ~(8'b1 << r_idx);
      r_seg <= w_blank ? 7'h7F : decode(w_nib);
    end
  end

  assign bus.update_ack = r_ack;
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Randomized and directed bench for hex_scan_driver against a cycle-count
// based reference model of capture, scan position and nibble decoding.
module tb_hex_scan_driver;
  localparam int unsigned DIV = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hex_scan_driver_if bus();

  hex_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [31:0] m_data = '0;
  logic        m_ack  = 1'b0;
  int          n      = 0;   // non-reset edges since the last reset edge

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_seg(input logic [31:0] data, input int d, input logic blz);
    logic [31:0] upper;
    upper = data >> (4 * d);
    if (blz && d > 0 && upper == 0) return 7'h7F;
    return dec_tbl[upper[3:0]];
  endfunction

  // One clock edge: predict outputs from pre-edge state, advance model, compare.
  task automatic step();
    logic [7:0] e_an;
    logic [6:0] e_seg;
    int d;
    if (reset) begin
      e_an  = 8'hFF;
      e_seg = 7'h7F;
    end else begin
      d     = (n / DIV) % 8;
      e_an  = ~(8'h01 << d);
      e_seg = digit_seg(m_data, d, bus.blank_lz);
    end
    @(posedge clock);
    #1;
    if (reset) begin
      m_data = '0;
      m_ack  = 1'b0;
      n      = 0;
    end else begin
      if (bus.update_req && !m_ack) begin
        m_data = bus.hexDisplay;
        m_ack  = 1'b1;
      end else if (!bus.update_req && m_ack) begin
        m_ack = 1'b0;
      end
      n++;
    end
    chk("ack", 32'(bus.update_ack), 32'(m_ack));
    chk("an",  32'(bus.an),  32'(e_an));
    chk("seg", 32'(bus.seg), 32'(e_seg));
    if (!reset) chk("onehot", 32'($countones(~bus.an)), 32'd1);
  endtask

  initial begin
    reset              = 1'b1;
    bus.update_req     = 1'b0;
    bus.hexDisplay     = '0;
    bus.blank_lz       = 1'b0;

    // Reset, then free scan of the zero word
    repeat (3) step();
    reset = 1'b0;
    repeat (40) step();

    // Single-cycle request pulse and full scan of a known word
    bus.hexDisplay = 32'h0123ABCD;
    bus.update_req = 1'b1;
    step();
    bus.update_req = 1'b0;
    repeat (40) step();

    // Request held: data changes must not be captured until req drops and rises
    bus.hexDisplay = 32'h13572468;
    bus.update_req = 1'b1;
    step();
    bus.hexDisplay = 32'hFFFFFFFF;
    repeat (34) step();
    bus.update_req = 1'b0;
    step();
    bus.update_req = 1'b1;
    repeat (2) step();
    bus.update_req = 1'b0;
    repeat (34) step();

    // Leading-zero blanking
    bus.blank_lz   = 1'b1;
    bus.hexDisplay = 32'h000000F0;
    bus.update_req = 1'b1;
    step();
    bus.update_req = 1'b0;
    repeat (34) step();
    bus.hexDisplay = 32'h0;
    bus.update_req = 1'b1;
    step();
    bus.update_req = 1'b0;
    repeat (34) step();
    bus.blank_lz   = 1'b0;
    repeat (4) step();

    // Reset mid-scan (counter=2, digit=5) with handshake open, req held across release
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.hexDisplay = $urandom;
    bus.update_req = 1'b1;
    while (n < 22) step();
    reset = 1'b1;
    step();
    chk("rst_ack", 32'(bus.update_ack), 32'd0);
    chk("rst_an",  32'(bus.an), 32'hFF);
    reset = 1'b0;
    bus.hexDisplay = 32'h00C0FFEE;
    step();
    chk("rel_ack", 32'(bus.update_ack), 32'd1);
    bus.update_req = 1'b0;
    repeat (3) step();

    // Random traffic
    repeat (1000) begin
      if ($urandom_range(0, 3) == 0) bus.hexDisplay = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 2) == 0) bus.update_req = ~bus.update_req;
      if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
